// File: rtl/im_fetch_arbiter.sv
// Two-requester arbiter for the 1-cycle-latency instruction memory: fetch (F) has priority, debug (D) gets a starvation guard.
// Optional performance counters are built when IM_ARB_PERF_EN is defined.
//
// tag      | meaning
// TAG_NONE | no read in flight, both rvalid low
// TAG_F    | IM data this cycle belongs to fetch
// TAG_D    | IM data this cycle belongs to debug
module im_fetch_arbiter #(
  parameter int N            = 7,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             f_valid,
  input  logic [N-1:0]     f_addr,
  output logic             f_ready,
  output logic             f_rvalid,
  output logic [31:0]      f_rdata,
  input  logic             d_valid,
  input  logic [N-1:0]     d_addr,
  output logic             d_ready,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic [N-1:0]     im_addra,
  input  logic [31:0]      im_douta
`ifdef IM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_f_grants,
  output logic [CNT_W-1:0] perf_d_grants,
  output logic [CNT_W-1:0] perf_conflicts
`endif
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT   = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] CNT_MAX = '1;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_F    = 2'd1;
  localparam logic [1:0] TAG_D    = 2'd2;

  logic [SW-1:0] starve_cnt;
  logic [N-1:0]  last_addr;
  logic [1:0]    tag;
  logic          d_pri;

  assign d_pri = (starve_cnt >= LIMIT);

  // Ready doubles as the grant; rst_n gates it so nothing is granted while reset is held.
  always_comb begin
    f_ready = rst_n & f_valid & ~(d_valid & d_pri);
    d_ready = rst_n & d_valid & (~f_valid | d_pri);
  end

  always_comb begin
    im_addra = last_addr;
    if (f_ready)      im_addra = f_addr;
    else if (d_ready) im_addra = d_addr;
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      last_addr  <= '0;
      tag        <= TAG_NONE;
      starve_cnt <= '0;
    end else begin
      if (f_ready)      last_addr <= f_addr;
      else if (d_ready) last_addr <= d_addr;

      if (f_ready)      tag <= TAG_F;
      else if (d_ready) tag <= TAG_D;
      else              tag <= TAG_NONE;

      if (!d_valid || d_ready)     starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_comb begin
    f_rvalid = (tag == TAG_F);
    d_rvalid = (tag == TAG_D);
    f_rdata  = f_rvalid ? im_douta : 32'h0;
    d_rdata  = d_rvalid ? im_douta : 32'h0;
  end

`ifdef IM_ARB_PERF_EN
  localparam logic [CNT_W-1:0] PERF_MAX = '1;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      perf_f_grants  <= '0;
      perf_d_grants  <= '0;
      perf_conflicts <= '0;
    end else begin
      if (f_ready && perf_f_grants != PERF_MAX)
        perf_f_grants <= perf_f_grants + CNT_W'(1);
      if (d_ready && perf_d_grants != PERF_MAX)
        perf_d_grants <= perf_d_grants + CNT_W'(1);
      if (f_valid && d_valid && perf_conflicts != PERF_MAX)
        perf_conflicts <= perf_conflicts + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_im_fetch_arbiter.sv
// Scoreboard bench for im_fetch_arbiter: directed steps push expected responses, a monitor pops them.
module tb_im_fetch_arbiter;

  logic        clka = 1'b0;
  logic        rst_n;
  logic        f_valid, d_valid;
  logic [6:0]  f_addr, d_addr;
  logic        f_ready, d_ready, f_rvalid, d_rvalid;
  logic [31:0] f_rdata, d_rdata, im_douta;
  logic [6:0]  im_addra;
`ifdef IM_ARB_PERF_EN
  logic [15:0] perf_f_grants, perf_d_grants, perf_conflicts;
`endif

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb[$];
  logic [6:0]  exp_last;
  logic [31:0] mem [128];

  always #5 clka = ~clka;

  im_fetch_arbiter #(.N(7), .STARVE_LIMIT(4), .CNT_W(16)) dut (
    .clka(clka), .rst_n(rst_n),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .im_addra(im_addra), .im_douta(im_douta)
`ifdef IM_ARB_PERF_EN
    ,
    .perf_f_grants(perf_f_grants), .perf_d_grants(perf_d_grants),
    .perf_conflicts(perf_conflicts)
`endif
  );

  function automatic logic [31:0] mem_val(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ 8'h5A, 8'hC3, ~b, b};
  endfunction

  initial for (int i = 0; i < 128; i++) mem[i] = mem_val(i);

  // Synchronous IM model: registered read, one cycle latency.
  always @(posedge clka) im_douta <= mem[im_addra];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle starting at a negedge; exp_g: 0 none, 1 F, 2 D.
  task automatic step(input logic fv, input logic [6:0] fa, input logic dv,
                      input logic [6:0] da, input int exp_g, input string nm);
    logic [6:0] ea;
    f_valid = fv; f_addr = fa; d_valid = dv; d_addr = da;
    #1;
    ea = (exp_g == 1) ? fa : (exp_g == 2) ? da : exp_last;
    chk({nm, "_f_ready"}, 32'(f_ready), 32'(exp_g == 1));
    chk({nm, "_d_ready"}, 32'(d_ready), 32'(exp_g == 2));
    chk({nm, "_im_addra"}, 32'(im_addra), 32'(ea));
    exp_last = ea;
    #2;
    if (exp_g == 1) sb.push_back({1'b0, mem_val(int'(fa))});
    if (exp_g == 2) sb.push_back({1'b1, mem_val(int'(da))});
    @(negedge clka);
  endtask

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clka);
      #2;
      if (f_rvalid || d_rvalid) begin
        if (f_rvalid && d_rvalid) chk("both_rvalid", 32'(d_rvalid), 32'h0);
        if (sb.size() == 0) begin
          chk("unexpected_rvalid", 32'({f_rvalid, d_rvalid}), 32'h0);
        end else begin
          e = sb.pop_front();
          if (e[32]) begin
            chk("d_rvalid", 32'(d_rvalid), 32'h1);
            chk("d_rdata", d_rdata, e[31:0]);
            chk("f_rdata_zero", f_rdata, 32'h0);
          end else begin
            chk("f_rvalid", 32'(f_rvalid), 32'h1);
            chk("f_rdata", f_rdata, e[31:0]);
            chk("d_rdata_zero", d_rdata, 32'h0);
          end
        end
      end else begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("missing_rvalid", 32'(f_rvalid | d_rvalid), 32'h1);
        end
        chk("rdata_idle", f_rdata | d_rdata, 32'h0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst_n = 1'b1;
    f_valid = 1'b1; d_valid = 1'b1; f_addr = 7'h05; d_addr = 7'h06;
    exp_last = 7'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clka);
    #1;
    chk("rst_f_ready", 32'(f_ready), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    chk("rst_rvalid", 32'({f_rvalid, d_rvalid}), 32'h0);
    chk("rst_rdata", f_rdata | d_rdata, 32'h0);
    chk("rst_im_addra", 32'(im_addra), 32'h0);
    @(negedge clka);
    rst_n = 1'b1;
    step(1, 7'h05, 1, 7'h06, 1, "s1_first");
    step(0, 7'h00, 0, 7'h00, 0, "s1_idle");

    for (int i = 0; i < 4; i++) step(1, 7'(i), 0, 7'h00, 1, "s2_f_only");
    step(0, 7'h00, 0, 7'h00, 0, "s2_idle");

    step(0, 7'h00, 1, 7'h10, 2, "s4_d_only");
    step(0, 7'h00, 0, 7'h00, 0, "s4_idle");

    // Dropping d_valid must clear the starvation count.
    step(1, 7'h40, 1, 7'h41, 1, "clr_a");
    step(1, 7'h42, 1, 7'h41, 1, "clr_b");
    step(1, 7'h43, 0, 7'h41, 1, "clr_drop");
    for (int i = 0; i < 4; i++) step(1, 7'(8'h44 + i), 1, 7'h41, 1, "clr_f");
    step(1, 7'h48, 1, 7'h41, 2, "clr_d");
    step(0, 7'h00, 0, 7'h00, 0, "clr_idle");

    step(1, 7'h20, 1, 7'h20, 1, "same_f");
    step(0, 7'h20, 1, 7'h20, 2, "same_d");
    step(0, 7'h00, 0, 7'h00, 0, "same_idle");

    // Reset arrives right after the edge that captured a D grant.
    f_valid = 1'b0; d_valid = 1'b1; d_addr = 7'h33;
    #1 chk("s5_d_ready", 32'(d_ready), 32'h1);
    @(posedge clka);
    #1 rst_n = 1'b0;
    f_valid = 1'b1;
    #1;
    chk("s5_rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("s5_rst_ready", 32'({f_ready, d_ready}), 32'h0);
    chk("s5_rst_im_addra", 32'(im_addra), 32'h0);
    repeat (2) @(posedge clka);
    #1 chk("s5_rst_im_addra2", 32'(im_addra), 32'h0);
    @(negedge clka);
    rst_n = 1'b1;
    exp_last = 7'h0;
    for (int i = 0; i < 3; i++) step(0, 7'h00, 0, 7'h00, 0, "s5_post");

    for (int i = 0; i < 10; i++)
      step(1, 7'(8'h50 + i), 1, 7'h61, (i % 5 == 4) ? 2 : 1, "s3_pattern");
`ifdef IM_ARB_PERF_EN
    #1;
    chk("perf_f_grants", 32'(perf_f_grants), 32'd8);
    chk("perf_d_grants", 32'(perf_d_grants), 32'd2);
    chk("perf_conflicts", 32'(perf_conflicts), 32'd10);
    @(negedge clka);
`endif
    step(0, 7'h00, 0, 7'h00, 0, "end_idle");
    step(0, 7'h00, 0, 7'h00, 0, "end_idle");
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
